// File: rtl/pio_out_blink.sv
// Avalon-MM output PIO with readback, atomic set/clear and per-bit hardware blink.
// Optional feature macro: PIO_OUT_BLINK_EN (prescaler, BLINK_MASK, BLINK_DIV, STATUS).
module pio_out_blink #(
    parameter int               WIDTH       = 18,
    parameter int               DIV_W       = 24,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic             read_n,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    typedef enum logic [2:0] {
        ADDR_DATA   = 3'd0,
        ADDR_SET    = 3'd1,
        ADDR_CLEAR  = 3'd2,
        ADDR_MASK   = 3'd3,
        ADDR_DIV    = 3'd4,
        ADDR_STATUS = 3'd5
    } regAddr_t;

    logic             w_wr;
    logic             w_rd;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_data_next;
    logic [WIDTH-1:0] w_blink_bits;
    logic [31:0]      w_rd_val;
    logic             w_unused_bits;
    logic [WIDTH-1:0] r_data;

    assign w_wr          = chipselect & ~write_n;
    assign w_rd          = chipselect & ~read_n;
    assign w_wdata       = writedata[WIDTH-1:0];
    // Upper writedata bits are architecturally ignored.
    assign w_unused_bits = ^writedata;

    always_comb begin
        w_data_next = r_data;
        if (w_wr) begin
            case (address)
                ADDR_DATA:  w_data_next = w_wdata;
                ADDR_SET:   w_data_next = r_data | w_wdata;
                ADDR_CLEAR: w_data_next = r_data & ~w_wdata;
                default:    w_data_next = r_data;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= RESET_VALUE;
        end else begin
            r_data <= w_data_next;
        end
    end

`ifdef PIO_OUT_BLINK_EN
    logic [WIDTH-1:0] r_mask;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic             r_phase;
    logic             w_wr_mask;
    logic             w_wr_div;
    logic             w_blink_on;

    assign w_wr_mask  = w_wr && (address == ADDR_MASK);
    assign w_wr_div   = w_wr && (address == ADDR_DIV);
    assign w_blink_on = (r_div != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= '0;
            r_div  <= '0;
        end else begin
            if (w_wr_mask) begin
                r_mask <= writedata[WIDTH-1:0];
            end
            if (w_wr_div) begin
                r_div <= writedata[DIV_W-1:0];
            end
        end
    end

    // A BLINK_DIV write restarts the half-period from phase 0 and wins over a toggle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_wr_div || !w_blink_on) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (r_cnt == r_div) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign w_blink_bits = r_mask & {WIDTH{r_phase}};

    always_comb begin
        w_rd_val = '0;
        case (address)
            ADDR_DATA, ADDR_SET, ADDR_CLEAR: w_rd_val[WIDTH-1:0] = r_data;
            ADDR_MASK:                       w_rd_val[WIDTH-1:0] = r_mask;
            ADDR_DIV:                        w_rd_val[DIV_W-1:0] = r_div;
            ADDR_STATUS:                     w_rd_val[1:0]       = {w_blink_on, r_phase};
            default:                         w_rd_val            = '0;
        endcase
    end
`else
    assign w_blink_bits = '0;

    always_comb begin
        w_rd_val = '0;
        case (address)
            ADDR_DATA, ADDR_SET, ADDR_CLEAR: w_rd_val[WIDTH-1:0] = r_data;
            default:                         w_rd_val            = '0;
        endcase
    end
`endif

    // Reads are zero-latency; reset also forces the bus quiet.
    assign readdata = (reset_n && w_rd) ? w_rd_val : '0;
    assign out_port = r_data ^ w_blink_bits;

endmodule

// File: tb/tb_pio_out_blink.sv
// Self-checking bench for pio_out_blink: phase-from-elapsed-time model plus directed literal checks.
module tb_pio_out_blink;

    localparam int               WIDTH = 18;
    localparam int               DIV_W = 24;
    localparam logic [WIDTH-1:0] RV    = 18'h00005;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [2:0]       address = '0;
    logic             chipselect = 1'b0;
    logic             write_n = 1'b1;
    logic [31:0]      writedata = '0;
    logic             read_n = 1'b1;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;

    int checkCount = 0;
    int errorCount = 0;
    bit checkEn = 1'b0;

    pio_out_blink #(.WIDTH(WIDTH), .DIV_W(DIV_W), .RESET_VALUE(RV)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .read_n(read_n),
        .readdata(readdata), .out_port(out_port)
    );

    always #5 clk = ~clk;

    // Model: phase is derived from clocks elapsed since the last BLINK_DIV write.
    logic [WIDTH-1:0] mData = RV;
    logic [WIDTH-1:0] mMask = '0;
    logic [DIV_W-1:0] mDiv  = '0;
    int               mTick = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mData <= RV;
            mMask <= '0;
            mDiv  <= '0;
            mTick <= 0;
        end else begin
            mTick <= mTick + 1;
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: mData <= writedata[WIDTH-1:0];
                    3'd1: mData <= mData | writedata[WIDTH-1:0];
                    3'd2: mData <= mData & ~writedata[WIDTH-1:0];
`ifdef PIO_OUT_BLINK_EN
                    3'd3: mMask <= writedata[WIDTH-1:0];
                    3'd4: begin
                        mDiv  <= writedata[DIV_W-1:0];
                        mTick <= 0;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    function automatic logic modelPhase();
        if (mDiv == '0) return 1'b0;
        return ((mTick / (int'(mDiv) + 1)) % 2) == 1;
    endfunction

    function automatic logic [31:0] modelRead();
        logic [31:0] v;
        v = '0;
        if (!reset_n || !chipselect || read_n) return v;
        case (address)
            3'd0, 3'd1, 3'd2: v = 32'(mData);
`ifdef PIO_OUT_BLINK_EN
            3'd3: v = 32'(mMask);
            3'd4: v = 32'(mDiv);
            3'd5: v = {30'd0, mDiv != '0, modelPhase()};
`endif
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model out_port", 32'(out_port), 32'(mData ^ (mMask & {WIDTH{modelPhase()}})));
            checkOutput("model readdata", readdata, modelRead());
        end
    end

    task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        read_n     = 1'b1;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic readReg(input logic [2:0] addr, output logic [31:0] value);
        address    = addr;
        chipselect = 1'b1;
        read_n     = 1'b0;
        write_n    = 1'b1;
        @(negedge clk);
        value = readdata;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        read_n     = 1'b1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] rv;

    initial begin
        chipselect = 1'b1;
        read_n     = 1'b0;
        address    = 3'd0;
        #6 checkEn = 1'b1;
        #6;
        checkOutput("reset out_port", 32'(out_port), 32'h5);
        checkOutput("reset readdata", readdata, 32'h0);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        read_n     = 1'b1;

        readReg(3'd0, rv);
        checkOutput("data after reset", rv, 32'h5);
        applyStimulus(3'd0, 32'hFFFF_FFFF);
        readReg(3'd0, rv);
        checkOutput("data all ones", rv, 32'h0003_FFFF);
        applyStimulus(3'd2, 32'h0000_00F0);
        readReg(3'd2, rv);
        checkOutput("clear bits", rv, 32'h0003_FF0F);
        applyStimulus(3'd1, 32'h0000_0030);
        readReg(3'd1, rv);
        checkOutput("set bits", rv, 32'h0003_FF3F);

        address    = 3'd0;
        writedata  = 32'h0;
        chipselect = 1'b1;
        write_n    = 1'b0;
        read_n     = 1'b0;
        @(negedge clk);
        checkOutput("read during write", readdata, 32'h0003_FF3F);
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        read_n     = 1'b1;
        checkOutput("data after write", 32'(out_port), 32'h0);

`ifdef PIO_OUT_BLINK_EN
        applyStimulus(3'd3, 32'h1);
        applyStimulus(3'd4, 32'h3);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checkOutput("blink div3", 32'(out_port[0]), 32'((i / 4) % 2));
        end
        @(posedge clk);
        #1;
        readReg(3'd5, rv);
        checkOutput("status phase0", rv, 32'h2);
        waitCycles(3);
        readReg(3'd5, rv);
        checkOutput("status phase1", rv, 32'h3);

        applyStimulus(3'd4, 32'h1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("blink div1", 32'(out_port[0]), 32'((i / 2) % 2));
        end
        @(posedge clk);
        #1;
        applyStimulus(3'd4, 32'h0);
        applyStimulus(3'd0, 32'h1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("blink off", 32'(out_port), 32'h1);
        end
        @(posedge clk);
        #1;
        applyStimulus(3'd0, 32'h0);
        applyStimulus(3'd4, 32'h3);
        waitCycles(4);
        checkOutput("pre-reset phase1", 32'(out_port), 32'h1);
`else
        applyStimulus(3'd0, 32'h2A);
        applyStimulus(3'd3, 32'h1);
        applyStimulus(3'd4, 32'h2);
        readReg(3'd3, rv);
        checkOutput("disabled mask read", rv, 32'h0);
        readReg(3'd4, rv);
        checkOutput("disabled div read", rv, 32'h0);
        readReg(3'd5, rv);
        checkOutput("disabled status read", rv, 32'h0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checkOutput("disabled steady", 32'(out_port), 32'h2A);
        end
        @(posedge clk);
        #1;
        applyStimulus(3'd0, 32'h3);
        checkOutput("pre-reset data", 32'(out_port), 32'h3);
`endif

        #2 reset_n = 1'b0;
        #1;
        checkOutput("async reset out_port", 32'(out_port), 32'h5);
        checkOutput("async reset readdata", readdata, 32'h0);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        readReg(3'd3, rv);
        checkOutput("mask after reset", rv, 32'h0);
        readReg(3'd4, rv);
        checkOutput("div after reset", rv, 32'h0);
        readReg(3'd0, rv);
        checkOutput("data after async reset", rv, 32'h5);
        waitCycles(2);

        checkEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
